// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the block-RAM port arbiter and its picker.
package ram_port_arbiter_pkg;

  // One bit selects between the two requesters.
  localparam int unsigned MIDX_W = 1;

  // RAM size shared by the top level and the arbiter.
  localparam int unsigned DEF_RAM_DEPTH = 1024;

  // Wide enough to hold a read latency of 1..4 cycles.
  localparam int unsigned CNT_W = 3;

  typedef logic [MIDX_W-1:0] midx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a conflict, the master that did not win last time wins.
module rr_pick2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  midx_t      last,
  output logic       grant_valid,
  output midx_t      grant_idx
);

  // Pick the lone requester, or alternate away from the previous winner.
  always_comb begin
    grant_valid = |req;
    grant_idx   = midx_t'(0);
    if (req == 2'b11) begin
      grant_idx = ~last;
    end else if (req[1]) begin
      grant_idx = midx_t'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares block-RAM port A between two requesters: grant, one-cycle enable,
// read-latency wait, acknowledge. Out-of-range addresses never reach the RAM.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_rw,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_rw,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  state_t           state_q, state_d;
  midx_t            rr_last_q, rr_last_d;
  midx_t            idx_q, idx_d;
  logic             rw_q, rw_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             err_pend_q, err_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;

  logic             grant_valid;
  midx_t            grant_idx;
  logic             sel_rw;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  rr_pick2 u_pick (
    .req         ({m1_req, m0_req}),
    .last        (rr_last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Route the winning master's request fields toward the latch.
  always_comb begin
    sel_rw    = m0_rw;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (grant_idx == midx_t'(1)) begin
      sel_rw    = m1_rw;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Next-state and next-latch logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    idx_d      = idx_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_pend_d = err_pend_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          // Every grant updates the pointer, so a master that waited one
          // foreign access always wins the next conflict.
          idx_d     = grant_idx;
          rr_last_d = grant_idx;
          rw_d      = sel_rw;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          if (sel_addr >= AW'(RAM_DEPTH)) begin
            err_pend_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (rw_q) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(READ_LAT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        err_pend_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request, round-robin pointer, error flag and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q  <= midx_t'(1);
      idx_q      <= midx_t'(0);
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_pend_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      idx_q      <= idx_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_pend_q <= err_pend_d;
      cnt_q      <= cnt_d;
    end
  end

  // Registered handshake, RAM strobes and per-master read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= (state_d == ST_RESP) && (idx_d == midx_t'(0));
      m0_err <= (state_d == ST_RESP) && (idx_d == midx_t'(0)) && err_pend_d;
      m1_ack <= (state_d == ST_RESP) && (idx_d == midx_t'(1));
      m1_err <= (state_d == ST_RESP) && (idx_d == midx_t'(1)) && err_pend_d;
      mem_en <= (state_d == ST_ISSUE);
      mem_we <= (state_d == ST_ISSUE) && rw_d;
      if (capture && (idx_q == midx_t'(0))) begin
        m0_rdata <= mem_dout;
      end
      if (capture && (idx_q == midx_t'(1))) begin
        m1_rdata <= mem_dout;
      end
    end
  end

  // Address and write data hold the latched values between accesses.
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: one instance with READ_LAT=1, one with READ_LAT=3.
module tb_ram_port_arbiter;

  typedef struct {
    int          m;
    logic        err;
    logic        chk;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int lat;
    int en_cyc;
    int en_cnt;
    int we_cnt;
  } res_t;

  logic clk;
  logic reset;

  logic [1:0]       a_req, a_rw, a_ack, a_err;
  logic [1:0][31:0] a_addr, a_wdata, a_rdata;
  logic             a_mem_en, a_mem_we;
  logic [31:0]      a_mem_addr, a_mem_din, a_mem_dout;

  logic [1:0]       b_req, b_rw, b_ack, b_err;
  logic [1:0][31:0] b_addr, b_wdata, b_rdata;
  logic             b_mem_en, b_mem_we;
  logic [31:0]      b_mem_addr, b_mem_din, b_mem_dout;

  logic [31:0] ram_a [1024];
  logic [31:0] ram_b [16];
  logic [31:0] b_p1, b_p2;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   checks = 0;
  int   errors = 0;

  ram_port_arbiter #(.AW(32), .DW(32), .RAM_DEPTH(1024), .READ_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(a_req[0]), .m0_rw(a_rw[0]), .m0_addr(a_addr[0]), .m0_wdata(a_wdata[0]),
    .m0_ack(a_ack[0]), .m0_err(a_err[0]), .m0_rdata(a_rdata[0]),
    .m1_req(a_req[1]), .m1_rw(a_rw[1]), .m1_addr(a_addr[1]), .m1_wdata(a_wdata[1]),
    .m1_ack(a_ack[1]), .m1_err(a_err[1]), .m1_rdata(a_rdata[1]),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_din(a_mem_din), .mem_dout(a_mem_dout)
  );

  ram_port_arbiter #(.AW(32), .DW(32), .RAM_DEPTH(1024), .READ_LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(b_req[0]), .m0_rw(b_rw[0]), .m0_addr(b_addr[0]), .m0_wdata(b_wdata[0]),
    .m0_ack(b_ack[0]), .m0_err(b_err[0]), .m0_rdata(b_rdata[0]),
    .m1_req(b_req[1]), .m1_rw(b_rw[1]), .m1_addr(b_addr[1]), .m1_wdata(b_wdata[1]),
    .m1_ack(b_ack[1]), .m1_err(b_err[1]), .m1_rdata(b_rdata[1]),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_din(b_mem_din), .mem_dout(b_mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) ram_a[a_mem_addr[9:0]] <= a_mem_din;
      else          a_mem_dout <= ram_a[a_mem_addr[9:0]];
    end
  end

  // Block RAM model, three-cycle read latency.
  always @(posedge clk) begin
    if (b_mem_en && b_mem_we)  ram_b[b_mem_addr[3:0]] <= b_mem_din;
    if (b_mem_en && !b_mem_we) b_p1 <= ram_b[b_mem_addr[3:0]];
    b_p2       <= b_p1;
    b_mem_dout <= b_p2;
  end

  // Scoreboard for instance A: every ack pops one expected completion.
  always @(negedge clk) begin
    exp_t e;
    int   mi;
    if (!reset && a_ack != 2'b00) begin
      checks++;
      mi = a_ack[1] ? 1 : 0;
      if (a_ack == 2'b11) begin
        errors++;
        $display("FAIL a_dual_ack: ack=%b, required one-hot", a_ack);
      end else if (sb_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_ack: master %0d acked, no access pending", mi);
      end else begin
        e = sb_a.pop_front();
        if (mi != e.m || a_err[mi] !== e.err || (e.chk && a_rdata[mi] !== e.rdata)) begin
          errors++;
          $display("FAIL a_completion: got m%0d err=%b rdata=%h, required m%0d err=%b rdata=%h",
                   mi, a_err[mi], a_rdata[mi], e.m, e.err, e.rdata);
        end
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    exp_t e;
    int   mi;
    if (!reset && b_ack != 2'b00) begin
      checks++;
      mi = b_ack[1] ? 1 : 0;
      if (b_ack == 2'b11 || sb_b.size() == 0) begin
        errors++;
        $display("FAIL b_ack: ack=%b pending=%0d, required one-hot with a pending access", b_ack, sb_b.size());
      end else begin
        e = sb_b.pop_front();
        if (mi != e.m || b_err[mi] !== e.err || (e.chk && b_rdata[mi] !== e.rdata)) begin
          errors++;
          $display("FAIL b_completion: got m%0d err=%b rdata=%h, required m%0d err=%b rdata=%h",
                   mi, b_err[mi], b_rdata[mi], e.m, e.err, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // Present one request on instance d, master m; wait for its ack (called at a negedge).
  task automatic m_access(input int d, input int m, input logic w, input logic [31:0] ad,
                          input logic [31:0] wd, output res_t r);
    logic got;
    r   = '{lat: -1, en_cyc: -1, en_cnt: 0, we_cnt: 0};
    got = 1'b0;
    if (d == 0) begin
      a_rw[m] = w; a_addr[m] = ad; a_wdata[m] = wd; a_req[m] = 1'b1;
    end else begin
      b_rw[m] = w; b_addr[m] = ad; b_wdata[m] = wd; b_req[m] = 1'b1;
    end
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if ((d == 0 ? a_mem_en : b_mem_en) === 1'b1) begin
        r.en_cnt = r.en_cnt + 1;
        if ((d == 0 ? a_mem_we : b_mem_we) === 1'b1) r.we_cnt = r.we_cnt + 1;
        if (r.en_cyc < 0) r.en_cyc = n;
      end
      if ((d == 0 ? a_ack[m] : b_ack[m]) === 1'b1) begin
        got   = 1'b1;
        r.lat = n;
      end
    end
    if (d == 0) a_req[m] = 1'b0;
    else        b_req[m] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: dut %0d master %0d saw no ack in 40 cycles, ack required", d, m);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    res_t r;
    checks++;
    if (a_ack !== 2'b00 || a_err !== 2'b00 || a_mem_en !== 1'b0 || a_mem_we !== 1'b0 ||
        a_rdata !== '0 || a_mem_addr !== 32'h0 || a_mem_din !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: ack=%b err=%b en=%b we=%b addr=%h, required all zero",
               a_ack, a_err, a_mem_en, a_mem_we, a_mem_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    a_rw[0] = 1'b0; a_addr[0] = 32'd9; a_req[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_addr !== 32'd9) begin
      errors++;
      $display("FAIL abort_issue: en=%b addr=%h, required en=1 addr=9", a_mem_en, a_mem_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (a_mem_en !== 1'b0 || a_ack !== 2'b00 || a_mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset: en=%b ack=%b addr=%h, required 0/00/0", a_mem_en, a_ack, a_mem_addr);
    end
    a_req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL abort_rdata: m0_rdata=%h, required 0", a_rdata[0]);
    end
    sb_a.push_back('{0, 1'b0, 1'b1, 32'hA5A5_0005});
    m_access(0, 0, 1'b0, 32'd5, 32'h0, r);
    checks++;
    if (r.lat != 3) begin
      errors++;
      $display("FAIL post_reset_read_lat: ack cycle %0d, required 3", r.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    res_t r;
    sb_a.push_back('{0, 1'b0, 1'b0, 32'h0});
    m_access(0, 0, 1'b1, 32'h10, 32'hDEAD_BEEF, r);
    checks++;
    if (r.lat != 2 || r.en_cyc != 1 || r.en_cnt != 1 || r.we_cnt != 1) begin
      errors++;
      $display("FAIL write_timing: ack %0d en_cyc %0d en %0d we %0d, required 2 1 1 1",
               r.lat, r.en_cyc, r.en_cnt, r.we_cnt);
    end
    checks++;
    if (ram_a[16] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_commit: ram[0x10]=%h, required deadbeef", ram_a[16]);
    end
    @(negedge clk);
    sb_a.push_back('{0, 1'b0, 1'b1, 32'hDEAD_BEEF});
    m_access(0, 0, 1'b0, 32'h10, 32'h0, r);
    checks++;
    if (r.lat != 3 || r.en_cnt != 1 || r.we_cnt != 0) begin
      errors++;
      $display("FAIL read_timing: ack %0d en %0d we %0d, required 3 1 0", r.lat, r.en_cnt, r.we_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    res_t r0, r1;
    reset_pulse();
    sb_a.push_back('{0, 1'b0, 1'b1, 32'hDEAD_BEEF});
    sb_a.push_back('{1, 1'b0, 1'b1, 32'h2020_2020});
    fork
      m_access(0, 0, 1'b0, 32'h10, 32'h0, r0);
      m_access(0, 1, 1'b0, 32'h20, 32'h0, r1);
    join
    checks++;
    if (r0.lat != 3 || r1.lat != 7) begin
      errors++;
      $display("FAIL simultaneous_lat: m0 %0d m1 %0d, required 3 and 7", r0.lat, r1.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      sb_a.push_back('{0, 1'b0, 1'b1, 32'h3000_0000 + 32'(i)});
      sb_a.push_back('{1, 1'b0, 1'b0, 32'h0});
    end
    fork
      begin
        res_t r;
        for (int i = 0; i < 3; i++) begin
          m_access(0, 0, 1'b0, 32'h30 + 32'(i), 32'h0, r);
          checks++;
          if (r.lat != (i == 0 ? 3 : 6)) begin
            errors++;
            $display("FAIL b2b_m0_lat%0d: %0d, required %0d", i, r.lat, (i == 0 ? 3 : 6));
          end
          @(negedge clk);
        end
      end
      begin
        res_t r;
        for (int i = 0; i < 3; i++) begin
          m_access(0, 1, 1'b1, 32'h40 + 32'(i), 32'h4000_0000 + 32'(i), r);
          checks++;
          if (r.lat != 6) begin
            errors++;
            $display("FAIL b2b_m1_lat%0d: %0d, required 6", i, r.lat);
          end
          @(negedge clk);
        end
      end
    join
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ram_a[64 + i] !== 32'h4000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_ram%0d: %h, required %h", i, ram_a[64 + i], 32'h4000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_range();
    res_t r;
    logic [31:0] snap [1024];
    int diffs;
    sb_a.push_back('{1, 1'b0, 1'b1, 32'h0BAD_F00D});
    m_access(0, 1, 1'b0, 32'd1023, 32'h0, r);
    checks++;
    if (r.lat != 3 || r.en_cnt != 1) begin
      errors++;
      $display("FAIL range_last_ok: ack %0d en %0d, required 3 1", r.lat, r.en_cnt);
    end
    @(negedge clk);
    snap = ram_a;
    sb_a.push_back('{1, 1'b1, 1'b0, 32'h0});
    m_access(0, 1, 1'b1, 32'd1024, 32'hFFFF_FFFF, r);
    checks++;
    if (r.lat != 1 || r.en_cnt != 0) begin
      errors++;
      $display("FAIL range_wr_err: ack %0d en %0d, required 1 0", r.lat, r.en_cnt);
    end
    @(negedge clk);
    sb_a.push_back('{1, 1'b1, 1'b1, 32'h0BAD_F00D});
    m_access(0, 1, 1'b0, 32'd1024, 32'h0, r);
    @(negedge clk);
    sb_a.push_back('{0, 1'b1, 1'b0, 32'h0});
    m_access(0, 0, 1'b1, 32'h8000_0010, 32'h1234_4321, r);
    checks++;
    if (r.lat != 1 || r.en_cnt != 0) begin
      errors++;
      $display("FAIL range_high_bit: ack %0d en %0d, required 1 0", r.lat, r.en_cnt);
    end
    @(negedge clk);
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (ram_a[i] !== snap[i]) diffs++;
    checks++;
    if (diffs != 0) begin
      errors++;
      $display("FAIL range_ram_untouched: %0d words changed, required 0", diffs);
    end
  endtask

  task automatic test_isolation();
    res_t r0, r1;
    int stray;
    stray = 0;
    sb_a.push_back('{1, 1'b0, 1'b0, 32'h0});
    sb_a.push_back('{0, 1'b0, 1'b1, 32'hDEAD_BEEF});
    fork
      m_access(0, 1, 1'b1, 32'h50, 32'h5555_AAAA, r1);
      begin
        @(negedge clk);
        m_access(0, 0, 1'b0, 32'h10, 32'h0, r0);
      end
      begin
        repeat (2) begin
          @(negedge clk);
          if (a_ack[0] !== 1'b0) stray++;
        end
      end
    join
    checks++;
    if (r1.lat != 2 || r0.lat != 5 || stray != 0) begin
      errors++;
      $display("FAIL isolation: m1 ack %0d m0 ack %0d stray %0d, required 2 5 0", r1.lat, r0.lat, stray);
    end
    checks++;
    if (ram_a[80] !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL isolation_ram: %h, required 5555aaaa", ram_a[80]);
    end
    @(negedge clk);
  endtask

  task automatic test_latency();
    res_t r;
    sb_b.push_back('{0, 1'b0, 1'b1, 32'hCAFE_0003});
    m_access(1, 0, 1'b0, 32'd3, 32'h0, r);
    checks++;
    if (r.lat != 5) begin
      errors++;
      $display("FAIL lat3_m0: ack cycle %0d, required 5", r.lat);
    end
    @(negedge clk);
    sb_b.push_back('{1, 1'b0, 1'b1, 32'h1234_5678});
    m_access(1, 1, 1'b0, 32'd7, 32'h0, r);
    checks++;
    if (r.lat != 5 || b_rdata[0] !== 32'hCAFE_0003) begin
      errors++;
      $display("FAIL lat3_m1: ack cycle %0d m0_rdata %h, required 5 cafe0003", r.lat, b_rdata[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    a_req = '0; a_rw = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_rw = '0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 1024; i++) ram_a[i] <= 32'h0;
    for (int i = 0; i < 16; i++)   ram_b[i] <= 32'h0;
    ram_a[5]    <= 32'hA5A5_0005;
    ram_a[9]    <= 32'hA5A5_0009;
    ram_a[32]   <= 32'h2020_2020;
    ram_a[48]   <= 32'h3000_0000;
    ram_a[49]   <= 32'h3000_0001;
    ram_a[50]   <= 32'h3000_0002;
    ram_a[1023] <= 32'h0BAD_F00D;
    ram_b[3]    <= 32'hCAFE_0003;
    ram_b[7]    <= 32'h1234_5678;
    repeat (3) @(negedge clk);
    test_reset();
    test_write_read();
    test_arbitration();
    test_back_to_back();
    test_range();
    test_isolation();
    test_latency();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d completions outstanding, required 0/0", sb_a.size(), sb_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
